// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display prefetch FIFO vs. host req/ack port, one RAM access per cycle.
// Define VRAM_ARB_STATS_EN to build the saturating underflow statistics counter.
module vram_arbiter #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 16,
  parameter int FRAME_WORDS = 19200,
  parameter int FIFO_DEPTH  = 8,
  parameter int LOW_WATER   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_rd,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_empty,
  output logic              underflow,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       underflow_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LVL_W = CNT_W + 1;
  localparam int FA_W  = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {GRANT_IDLE, GRANT_DISP, GRANT_HOST} grant_e;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  logic [FA_W-1:0]   fetch_addr_q, fetch_addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              disp_cmd_q, disp_cmd_d, disp_ret_q, disp_ret_d;
  logic              host_wr_ack_q, host_wr_ack_d;
  logic              host_rd_cmd_q, host_rd_cmd_d, host_rd_ret_q, host_rd_ret_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] pix_data_q, pix_data_d;
  logic              underflow_q, underflow_d;

  logic [LVL_W-1:0]  level;
  logic              fetch_ok, urgent, host_busy, host_ok;
  logic              push, pop_ok, under_pop;
  grant_e            grant;

  // A display read is in flight both while its command is on the RAM and while its data returns.
  assign level     = LVL_W'(count_q) + LVL_W'(disp_cmd_q) + LVL_W'(disp_ret_q);
  assign fetch_ok  = (fetch_addr_q < FA_W'(FRAME_WORDS)) && (level < LVL_W'(FIFO_DEPTH))
                     && !frame_start;
  assign urgent    = fetch_ok && (level < LVL_W'(LOW_WATER));
  assign host_busy = host_wr_ack_q | host_rd_cmd_q | host_rd_ret_q;
  assign host_ok   = host_req && !host_busy && !host_ack;

  assign push      = disp_ret_q && !frame_start;
  assign pop_ok    = pix_rd && (count_q != '0) && !frame_start;
  assign under_pop = pix_rd && (count_q == '0) && !frame_start;

  // NOTE: combinational blocks use blocking '=' and assign every output a default first,
  // so no latch can be inferred; only the clocked blocks use '<='.
  always_comb begin
    grant = GRANT_IDLE;
    if (urgent)        grant = GRANT_DISP;
    else if (host_ok)  grant = GRANT_HOST;
    else if (fetch_ok) grant = GRANT_DISP;
  end

  always_comb begin
    fetch_addr_d  = fetch_addr_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    ram_we_d      = 1'b0;
    disp_cmd_d    = 1'b0;
    host_wr_ack_d = 1'b0;
    host_rd_cmd_d = 1'b0;
    host_rd_ret_d = host_rd_cmd_q;
    disp_ret_d    = disp_cmd_q && !frame_start;

    unique case (grant)
      GRANT_DISP: begin
        ram_addr_d   = ADDR_W'(fetch_addr_q);
        fetch_addr_d = fetch_addr_q + FA_W'(1);
        disp_cmd_d   = 1'b1;
      end
      GRANT_HOST: begin
        ram_addr_d    = host_addr;
        ram_we_d      = host_we;
        host_wr_ack_d = host_we;
        host_rd_cmd_d = !host_we;
        if (host_we) ram_wdata_d = host_wdata;
      end
      default: ;
    endcase
    if (frame_start) fetch_addr_d = '0;

    unique case ({push, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop_ok);
    pix_data_d  = pop_ok ? mem[rd_ptr_q] : pix_data_q;
    underflow_d = underflow_q | under_pop;
    if (frame_start) begin
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_addr_q  <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      disp_cmd_q    <= 1'b0;
      disp_ret_q    <= 1'b0;
      host_wr_ack_q <= 1'b0;
      host_rd_cmd_q <= 1'b0;
      host_rd_ret_q <= 1'b0;
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= '0;
      pix_data_q    <= '0;
      underflow_q   <= 1'b0;
    end else begin
      fetch_addr_q  <= fetch_addr_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      disp_cmd_q    <= disp_cmd_d;
      disp_ret_q    <= disp_ret_d;
      host_wr_ack_q <= host_wr_ack_d;
      host_rd_cmd_q <= host_rd_cmd_d;
      host_rd_ret_q <= host_rd_ret_d;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
      pix_data_q    <= pix_data_d;
      underflow_q   <= underflow_d;
    end
  end

  // NOTE: FIFO storage has no reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= ram_rdata;
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (under_pop && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ucnt_q <= '0;
    else        ucnt_q <= ucnt_d;
  end

  assign underflow_cnt = ucnt_q;
`else
  assign underflow_cnt = '0;
`endif

  assign pix_data   = pix_data_q;
  assign pix_empty  = (count_q == '0);
  assign underflow  = underflow_q;
  assign host_ack   = host_wr_ack_q | host_rd_ret_q;
  assign host_rdata = host_rd_ret_q ? ram_rdata : '0;
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a synchronous single-port RAM model.
module tb_vram_arbiter;

  localparam int ADDR_W      = 15;
  localparam int DATA_W      = 16;
  localparam int FRAME_WORDS = 19200;
`ifdef VRAM_ARB_STATS_EN
  localparam logic [15:0] EXP_UCNT = 16'd3;
`else
  localparam logic [15:0] EXP_UCNT = 16'd0;
`endif

  logic              clk = 1'b0;
  logic              reset, frame_start, pix_rd;
  logic [DATA_W-1:0] pix_data;
  logic              pix_empty, underflow;
  logic              host_req, host_we, host_ack;
  logic [ADDR_W-1:0] host_addr, ram_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata, ram_wdata, ram_rdata;
  logic              ram_we;
  logic [15:0]       underflow_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_pix;

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_WORDS(FRAME_WORDS),
    .FIFO_DEPTH(8), .LOW_WATER(2)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .pix_rd(pix_rd), .pix_data(pix_data), .pix_empty(pix_empty), .underflow(underflow),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pat(input int a);
    return 16'(a * 7) ^ 16'hA5A5;
  endfunction

  // Synchronous read-first RAM; contents are loaded with pat() on the first clock edge.
  logic [DATA_W-1:0] vram [0:32767];
  logic              ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 32768; i++) vram[i] <= pat(i);
      ram_loaded <= 1'b1;
    end else if (ram_we) begin
      vram[ram_addr] <= ram_wdata;
    end
    ram_rdata <= vram[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; frame_start = 1'b1; pix_rd = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) step();
    n_tests++;
    if ({ram_addr, ram_we, ram_wdata, pix_data, underflow, host_ack, host_rdata} !== '0) begin
      $display("FAIL reset_outputs: got %h, expected 0",
               {ram_addr, ram_we, ram_wdata, pix_data, underflow, host_ack, host_rdata});
      n_fail++;
    end
    n_tests++;
    if (pix_empty !== 1'b1) begin
      $display("FAIL reset_pix_empty: got %b, expected 1", pix_empty); n_fail++;
    end
    n_tests++;
    if (underflow_cnt !== 16'd0) begin
      $display("FAIL reset_ucnt: got %0d, expected 0", underflow_cnt); n_fail++;
    end
    reset = 1'b1;
  endtask

  // frame_start is still high: first edge after reset release flushes, then 8 reads follow.
  task automatic test_prefill();
    logic [ADDR_W-1:0] exp_addr;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 1) frame_start = 1'b0;
      if (k >= 2) begin
        exp_addr = (k <= 9) ? ADDR_W'(k - 2) : ADDR_W'(7);
        n_tests++;
        if (ram_addr !== exp_addr || ram_we !== 1'b0) begin
          $display("FAIL prefill_addr cycle %0d: got addr %0d we %b, expected addr %0d we 0",
                   k, ram_addr, ram_we, exp_addr);
          n_fail++;
        end
      end
      n_tests++;
      if (pix_empty !== (k < 4)) begin
        $display("FAIL prefill_empty cycle %0d: got %b, expected %b", k, pix_empty, (k < 4));
        n_fail++;
      end
    end
  endtask

  task automatic test_stream();
    int errs = 0, uf = 0, first_bad = 0, max_addr = 0;
    logic [DATA_W-1:0] bad_got = '0;
    for (int i = 0; i < FRAME_WORDS; i++) begin
      pix_rd = 1'b1;
      step();
      pix_rd = 1'b0;
      if (pix_data !== pat(i)) begin
        if (errs == 0) begin first_bad = i; bad_got = pix_data; end
        errs++;
      end
      if (underflow !== 1'b0) uf++;
      for (int j = 0; j < 4; j++) begin
        if (!ram_we && int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
        if (j < 3) step();
      end
    end
    exp_pix = pat(FRAME_WORDS - 1);
    n_tests++;
    if (errs != 0) begin
      $display("FAIL stream_data: %0d bad words, first at pop %0d got %h expected %h",
               errs, first_bad, bad_got, pat(first_bad));
      n_fail++;
    end
    n_tests++;
    if (uf != 0) begin
      $display("FAIL stream_underflow: underflow high on %0d pops, expected 0", uf); n_fail++;
    end
    n_tests++;
    if (max_addr != FRAME_WORDS - 1) begin
      $display("FAIL stream_max_addr: got %0d, expected %0d", max_addr, FRAME_WORDS - 1);
      n_fail++;
    end
    repeat (6) step();
    n_tests++;
    if (pix_empty !== 1'b1 || ram_addr !== ADDR_W'(FRAME_WORDS - 1) || ram_we !== 1'b0) begin
      $display("FAIL stream_end: got empty %b addr %0d we %b, expected empty 1 addr %0d we 0",
               pix_empty, ram_addr, ram_we, FRAME_WORDS - 1);
      n_fail++;
    end
  endtask

  task automatic test_host_write();
    int lat = 0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (12) step();
    host_we = 1'b1; host_addr = 15'h0100; host_wdata = 16'hBEEF; host_req = 1'b1;
    do begin step(); lat++; end while (host_ack !== 1'b1 && lat < 10);
    n_tests++;
    if (lat != 1) begin
      $display("FAIL host_wr_latency: got %0d cycles, expected 1", lat); n_fail++;
    end
    n_tests++;
    if (ram_we !== 1'b1 || ram_addr !== 15'h0100 || ram_wdata !== 16'hBEEF) begin
      $display("FAIL host_wr_cmd: got we %b addr %h data %h, expected we 1 addr 0100 data beef",
               ram_we, ram_addr, ram_wdata);
      n_fail++;
    end
    host_req = 1'b0;
    step();
    n_tests++;
    if (host_ack !== 1'b0 || ram_we !== 1'b0) begin
      $display("FAIL host_wr_after: got ack %b we %b, expected 0 0", host_ack, ram_we); n_fail++;
    end
  endtask

  task automatic test_host_read();
    int lat = 0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic              cmd_we = 1'b0;
    host_we = 1'b0; host_addr = 15'h0100; host_req = 1'b1;
    do begin
      step(); lat++;
      if (lat == 1) begin cmd_addr = ram_addr; cmd_we = ram_we; end
    end while (host_ack !== 1'b1 && lat < 10);
    n_tests++;
    if (cmd_addr !== 15'h0100 || cmd_we !== 1'b0) begin
      $display("FAIL host_rd_cmd: got addr %h we %b, expected addr 0100 we 0", cmd_addr, cmd_we);
      n_fail++;
    end
    n_tests++;
    if (lat != 2) begin
      $display("FAIL host_rd_latency: got %0d cycles, expected 2", lat); n_fail++;
    end
    n_tests++;
    if (host_rdata !== 16'hBEEF) begin
      $display("FAIL host_rd_data: got %h, expected beef", host_rdata); n_fail++;
    end
    host_req = 1'b0;
    step();
    n_tests++;
    if (host_ack !== 1'b0) begin
      $display("FAIL host_rd_after: got ack %b, expected 0", host_ack); n_fail++;
    end
  endtask

  // Right after a flush the level is 1 with the first read in flight; display must win once.
  task automatic test_urgent_priority();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    host_we = 1'b1; host_addr = 15'h0200; host_wdata = 16'h1234; host_req = 1'b1;
    step();
    n_tests++;
    if (ram_addr !== 15'd1 || ram_we !== 1'b0 || host_ack !== 1'b0) begin
      $display("FAIL urgent_disp_first: got addr %h we %b ack %b, expected addr 0001 we 0 ack 0",
               ram_addr, ram_we, host_ack);
      n_fail++;
    end
    step();
    n_tests++;
    if (host_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 15'h0200) begin
      $display("FAIL urgent_host_next: got ack %b we %b addr %h, expected ack 1 we 1 addr 0200",
               host_ack, ram_we, ram_addr);
      n_fail++;
    end
    host_req = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_underflow();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pix_rd = 1'b1;
    repeat (3) step();
    pix_rd = 1'b0;
    n_tests++;
    if (underflow !== 1'b1) begin
      $display("FAIL uf_flag: got %b, expected 1", underflow); n_fail++;
    end
    n_tests++;
    if (pix_data !== exp_pix) begin
      $display("FAIL uf_pix_data: got %h, expected %h", pix_data, exp_pix); n_fail++;
    end
    n_tests++;
    if (underflow_cnt !== EXP_UCNT) begin
      $display("FAIL uf_count: got %0d, expected %0d", underflow_cnt, EXP_UCNT); n_fail++;
    end
    n_tests++;
    if (pix_empty !== 1'b0) begin
      $display("FAIL uf_return_kept: got empty %b, expected 0", pix_empty); n_fail++;
    end
    pix_rd = 1'b1;
    step();
    pix_rd = 1'b0;
    exp_pix = pat(0);
    n_tests++;
    if (pix_data !== exp_pix) begin
      $display("FAIL uf_first_word: got %h, expected %h", pix_data, exp_pix); n_fail++;
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    n_tests++;
    if (underflow !== 1'b0 || underflow_cnt !== EXP_UCNT) begin
      $display("FAIL uf_after_frame: got flag %b count %0d, expected flag 0 count %0d",
               underflow, underflow_cnt, EXP_UCNT);
      n_fail++;
    end
  endtask

  task automatic test_flush_inflight();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (3) step();
    n_tests++;
    if (ram_addr !== 15'd2 || pix_empty !== 1'b0) begin
      $display("FAIL flush_pre: got addr %0d empty %b, expected addr 2 empty 0", ram_addr, pix_empty);
      n_fail++;
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    n_tests++;
    if (pix_empty !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 15'd2) begin
      $display("FAIL flush_idle: got empty %b we %b addr %0d, expected empty 1 we 0 addr 2",
               pix_empty, ram_we, ram_addr);
      n_fail++;
    end
    for (int k = 0; k < 2; k++) begin
      step();
      n_tests++;
      if (pix_empty !== 1'b1 || ram_addr !== ADDR_W'(k)) begin
        $display("FAIL flush_refetch %0d: got empty %b addr %0d, expected empty 1 addr %0d",
                 k, pix_empty, ram_addr, k);
        n_fail++;
      end
    end
    step();
    n_tests++;
    if (pix_empty !== 1'b0) begin
      $display("FAIL flush_refill: got empty %b, expected 0", pix_empty); n_fail++;
    end
    for (int k = 0; k < 2; k++) begin
      pix_rd = 1'b1;
      step();
      pix_rd = 1'b0;
      n_tests++;
      if (pix_data !== pat(k)) begin
        $display("FAIL flush_word %0d: got %h, expected %h", k, pix_data, pat(k)); n_fail++;
      end
    end
  endtask

  task automatic test_reset_abort();
    int acks = 0;
    repeat (12) step();
    host_we = 1'b0; host_addr = 15'h0100; host_req = 1'b1;
    step();
    n_tests++;
    if (ram_addr !== 15'h0100 || ram_we !== 1'b0) begin
      $display("FAIL abort_cmd: got addr %h we %b, expected addr 0100 we 0", ram_addr, ram_we);
      n_fail++;
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (host_ack !== 1'b0 || ram_addr !== '0 || pix_empty !== 1'b1) begin
      $display("FAIL abort_immediate: got ack %b addr %h empty %b, expected 0 0000 1",
               host_ack, ram_addr, pix_empty);
      n_fail++;
    end
    host_req = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    repeat (4) begin
      step();
      if (host_ack !== 1'b0) acks++;
    end
    n_tests++;
    if (acks != 0) begin
      $display("FAIL abort_no_ack: got %0d acks, expected 0", acks); n_fail++;
    end
  endtask

  initial begin
    exp_pix = '0;
    test_reset();
    test_prefill();
    test_stream();
    test_host_write();
    test_host_read();
    test_urgent_priority();
    test_underflow();
    test_flush_inflight();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
